// File: rtl/rst_release_sequencer.sv
// Staged reset-release sequencer: waits for filtered PLL lock and external reset
// release, then frees per-domain resets one stage at a time; any abort re-asserts all.
module rst_release_sequencer #(
  parameter int NUM_STAGES  = 5,
  parameter int NUM_PLLS    = 2,
  parameter int CNT_W       = 16,
  parameter int STAGE_DELAY = 1000,
  parameter int LOCK_FILTER = 32,
  parameter int SW_RST_HOLD = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ext_rst_n,
  input  logic [NUM_PLLS-1:0]   pll_locked,
  input  logic                  sw_rst_req,
  output logic [NUM_STAGES-1:0] stage_rst_n,
  output logic                  seq_done,
  output logic [1:0]            seq_state,
  output logic [7:0]            lock_loss_cnt
);

  localparam int FILT_W = $clog2(LOCK_FILTER + 1);
  localparam int IDX_W  = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [FILT_W-1:0] FILT_MAX   = FILT_W'(LOCK_FILTER);
  localparam logic [CNT_W-1:0]  STAGE_LAST = CNT_W'(STAGE_DELAY - 1);
  localparam logic [CNT_W-1:0]  SW_LAST    = CNT_W'(SW_RST_HOLD - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NUM_STAGES - 1);

  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_RELEASE = 2'd1,
    S_RUN     = 2'd2,
    S_SW_HOLD = 2'd3
  } state_t;

  logic                  pll_all;
  logic                  all_ok;
  logic                  lock_ok;
  logic                  abort_lock;
  logic                  abort_sw;

  state_t                state_q, state_d;
  logic [FILT_W-1:0]     filt_q, filt_d;
  logic [CNT_W-1:0]      timer_q, timer_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_STAGES-1:0] stage_q, stage_d;
  logic                  done_q, done_d;
  logic [7:0]            loss_q, loss_d;

  assign pll_all = &pll_locked;
  assign all_ok  = pll_all && ext_rst_n;
  assign lock_ok = (filt_q == FILT_MAX);

  // Lock/reset qualification: any drop restarts the count from zero.
  always_comb begin
    filt_d = filt_q;
    if (!all_ok) begin
      filt_d = '0;
    end else if (filt_q != FILT_MAX) begin
      filt_d = filt_q + FILT_W'(1);
    end
  end

  // Lock loss outranks a software request arriving in the same cycle.
  assign abort_lock = (state_q != S_HOLD) && !all_ok;
  assign abort_sw   = sw_rst_req && ((state_q == S_RELEASE) || (state_q == S_RUN));

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    stage_d = stage_q;
    done_d  = done_q;
    loss_d  = loss_q;

    if (abort_lock) begin
      state_d = S_HOLD;
      timer_d = '0;
      idx_d   = '0;
      stage_d = '0;
      done_d  = 1'b0;
      if (!pll_all && (loss_q != 8'hFF)) begin
        loss_d = loss_q + 8'd1;
      end
    end else if (abort_sw) begin
      state_d = S_SW_HOLD;
      timer_d = '0;
      idx_d   = '0;
      stage_d = '0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        S_HOLD: begin
          timer_d = '0;
          idx_d   = '0;
          stage_d = '0;
          done_d  = 1'b0;
          if (lock_ok) begin
            state_d = S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (timer_q == STAGE_LAST) begin
            timer_d = '0;
            for (int i = 0; i < NUM_STAGES; i++) begin
              if (idx_q == IDX_W'(i)) begin
                stage_d[i] = 1'b1;
              end
            end
            if (idx_q == IDX_LAST) begin
              state_d = S_RUN;
              done_d  = 1'b1;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            timer_d = timer_q + CNT_W'(1);
          end
        end
        S_RUN: begin
          stage_d = '1;
          done_d  = 1'b1;
        end
        S_SW_HOLD: begin
          stage_d = '0;
          done_d  = 1'b0;
          if (timer_q == SW_LAST) begin
            state_d = S_HOLD;
            timer_d = '0;
          end else begin
            timer_d = timer_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = S_HOLD;
          timer_d = '0;
          idx_d   = '0;
          stage_d = '0;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_HOLD;
      filt_q  <= '0;
      timer_q <= '0;
      idx_q   <= '0;
      stage_q <= '0;
      done_q  <= 1'b0;
      loss_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      filt_q  <= filt_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      stage_q <= stage_d;
      done_q  <= done_d;
      loss_q  <= loss_d;
    end
  end

  assign stage_rst_n   = stage_q;
  assign seq_done      = done_q;
  assign seq_state     = state_q;
  assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_rst_release_sequencer.sv
// Bench for rst_release_sequencer: directed scenarios with literal expectations plus
// randomized stimulus, all checked every cycle against an elapsed-time reference model.
module tb_rst_release_sequencer;

  localparam int NS  = 5;
  localparam int NP  = 2;
  localparam int SD  = 4;
  localparam int LF  = 8;
  localparam int SWH = 16;

  logic          clk        = 1'b0;
  logic          rst_n      = 1'b0;
  logic          ext_rst_n  = 1'b0;
  logic [NP-1:0] pll_locked = '0;
  logic          sw_rst_req = 1'b0;
  logic [NS-1:0] stage_rst_n;
  logic          seq_done;
  logic [1:0]    seq_state;
  logic [7:0]    lock_loss_cnt;

  int total = 0;
  int bad   = 0;
  logic cmp_en = 1'b0;

  always #5 clk = ~clk;

  rst_release_sequencer #(
    .NUM_STAGES (NS),
    .NUM_PLLS   (NP),
    .CNT_W      (16),
    .STAGE_DELAY(SD),
    .LOCK_FILTER(LF),
    .SW_RST_HOLD(SWH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ext_rst_n    (ext_rst_n),
    .pll_locked   (pll_locked),
    .sw_rst_req   (sw_rst_req),
    .stage_rst_n  (stage_rst_n),
    .seq_done     (seq_done),
    .seq_state    (seq_state),
    .lock_loss_cnt(lock_loss_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase (0 hold, 1 release, 2 run, 3 sw hold), the edge at which the
  // phase began, and the length of the current all-ok run. Outputs follow from elapsed edges.
  int   m_state, m_n, m_t0, m_run, m_loss;
  logic m_ok;
  assign m_ok = (&pll_locked) && ext_rst_n;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state <= 0;
      m_n     <= 0;
      m_t0    <= 0;
      m_run   <= 0;
      m_loss  <= 0;
    end else begin
      m_n   <= m_n + 1;
      m_run <= m_ok ? m_run + 1 : 0;
      if (m_state != 0 && !m_ok) begin
        m_state <= 0;
        m_t0    <= m_n + 1;
        if (!(&pll_locked) && m_loss < 255) m_loss <= m_loss + 1;
      end else if (sw_rst_req && (m_state == 1 || m_state == 2)) begin
        m_state <= 3;
        m_t0    <= m_n + 1;
      end else if (m_state == 0 && m_run >= LF) begin
        m_state <= 1;
        m_t0    <= m_n + 1;
      end else if (m_state == 1 && (m_n + 1 - m_t0) == NS * SD) begin
        m_state <= 2;
      end else if (m_state == 3 && (m_n + 1 - m_t0) == SWH) begin
        m_state <= 0;
        m_t0    <= m_n + 1;
      end
    end
  end

  function automatic logic [NS-1:0] exp_stage(input int st, input int n, input int t0);
    logic [NS-1:0] r;
    int k;
    r = '0;
    if (st == 2) begin
      r = '1;
    end else if (st == 1) begin
      k = (n - t0) / SD;
      for (int i = 0; i < NS; i++) if (i < k) r[i] = 1'b1;
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("stage_rst_n", 32'(stage_rst_n), 32'(exp_stage(m_state, m_n, m_t0)));
      chk("seq_done", 32'(seq_done), 32'(m_state == 2));
      chk("seq_state", 32'(seq_state), 32'(m_state));
      chk("lock_loss_cnt", 32'(lock_loss_cnt), 32'(m_loss));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic set_ok();
    pll_locked = 2'b11;
    ext_rst_n  = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
  endtask

  initial begin
    // Reset values
    tick(1);
    cmp_en = 1'b1;
    chk("reset_stage", 32'(stage_rst_n), 32'h0);
    chk("reset_state", 32'(seq_state), 32'h0);
    chk("reset_loss", 32'(lock_loss_cnt), 32'h0);
    rst_n = 1'b1;
    tick(2);

    // Power-up sequence
    set_ok();
    tick(12);
    chk("pu_stage_e12", 32'(stage_rst_n), 32'h00);
    chk("pu_state_e12", 32'(seq_state), 32'd1);
    tick(1);
    chk("pu_stage_e13", 32'(stage_rst_n), 32'h01);
    tick(4);
    chk("pu_stage_e17", 32'(stage_rst_n), 32'h03);
    tick(11);
    chk("pu_done_e28", 32'(seq_done), 32'd0);
    tick(1);
    chk("pu_stage_e29", 32'(stage_rst_n), 32'h1F);
    chk("pu_done_e29", 32'(seq_done), 32'd1);
    chk("pu_state_e29", 32'(seq_state), 32'd2);
    chk("pu_loss", 32'(lock_loss_cnt), 32'd0);

    // Lock glitch inside the filter window
    do_reset();
    set_ok();
    tick(4);
    pll_locked = 2'b01;
    tick(1);
    pll_locked = 2'b11;
    tick(12);
    chk("glitch_stage_12", 32'(stage_rst_n), 32'h00);
    tick(1);
    chk("glitch_stage_13", 32'(stage_rst_n), 32'h01);
    chk("glitch_loss", 32'(lock_loss_cnt), 32'd0);

    // Lock loss in RUN
    tick(16);
    chk("run_stage", 32'(stage_rst_n), 32'h1F);
    pll_locked = 2'b01;
    tick(1);
    chk("loss_stage", 32'(stage_rst_n), 32'h00);
    chk("loss_done", 32'(seq_done), 32'd0);
    chk("loss_state", 32'(seq_state), 32'd0);
    chk("loss_cnt", 32'(lock_loss_cnt), 32'd1);
    tick(2);
    chk("loss_cnt_once", 32'(lock_loss_cnt), 32'd1);
    pll_locked = 2'b11;
    tick(12);
    chk("relock_stage_12", 32'(stage_rst_n), 32'h00);
    tick(1);
    chk("relock_stage_13", 32'(stage_rst_n), 32'h01);

    // Software reset in RELEASE after stage 1
    tick(4);
    chk("sw_pre_stage", 32'(stage_rst_n), 32'h03);
    sw_rst_req = 1'b1;
    tick(1);
    sw_rst_req = 1'b0;
    chk("sw_stage", 32'(stage_rst_n), 32'h00);
    chk("sw_state", 32'(seq_state), 32'd3);
    tick(15);
    chk("sw_state_last", 32'(seq_state), 32'd3);
    tick(1);
    chk("sw_to_hold", 32'(seq_state), 32'd0);
    tick(1);
    chk("sw_to_release", 32'(seq_state), 32'd1);
    tick(4);
    chk("sw_stage0", 32'(stage_rst_n), 32'h01);
    chk("sw_loss", 32'(lock_loss_cnt), 32'd1);

    // Simultaneous sw request and lock drop
    sw_rst_req = 1'b1;
    pll_locked = 2'b10;
    tick(1);
    sw_rst_req = 1'b0;
    chk("prio_state", 32'(seq_state), 32'd0);
    chk("prio_loss", 32'(lock_loss_cnt), 32'd2);
    sw_rst_req = 1'b1;
    tick(1);
    sw_rst_req = 1'b0;
    chk("sw_in_hold", 32'(seq_state), 32'd0);

    // Saturation of the lock-loss counter
    for (int i = 0; i < 300; i++) begin
      pll_locked = 2'b11;
      tick(9);
      pll_locked = 2'b01;
      tick(1);
    end
    chk("sat_loss", 32'(lock_loss_cnt), 32'd255);

    // Asynchronous reset mid-RELEASE
    pll_locked = 2'b11;
    tick(21);
    chk("async_pre_stage", 32'(stage_rst_n), 32'h07);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_stage", 32'(stage_rst_n), 32'h00);
    chk("async_done", 32'(seq_done), 32'd0);
    chk("async_state", 32'(seq_state), 32'd0);
    chk("async_loss", 32'(lock_loss_cnt), 32'd0);
    tick(1);
    rst_n = 1'b1;
    tick(1);

    // Randomized stimulus
    for (int c = 0; c < 4000; c++) begin
      pll_locked[0] = ($urandom_range(0, 63) != 0);
      pll_locked[1] = ($urandom_range(0, 63) != 0);
      ext_rst_n     = ($urandom_range(0, 99) != 0);
      sw_rst_req    = ($urandom_range(0, 29) == 0);
      rst_n         = ($urandom_range(0, 999) != 0);
      tick(1);
    end
    rst_n      = 1'b1;
    sw_rst_req = 1'b0;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rst_release_sequencer.md
Name: rst_release_sequencer

Overview:
Single-clock sequencer that owns the board's staged reset release. It waits for the external reset to be released and for every PLL to report stable lock. It then de-asserts a set of per-domain reset requests one stage at a time, with a fixed spacing between stages. On PLL lock loss, external reset, or a software reset request, it re-asserts all stages together and restarts the sequence. Its stage outputs feed the per-clock-domain reset resynchronisers.

Parameters:
NUM_STAGES, 5, number of reset stages released in order (bit 0 first), >=1
NUM_PLLS, 2, number of PLL lock inputs, >=1
CNT_W, 16, width of the stage/hold timer
STAGE_DELAY, 1000, cycles between stage releases, 1..2^CNT_W-1
LOCK_FILTER, 32, consecutive cycles that all locks and ext_rst_n must be high before sequencing starts, >=1
SW_RST_HOLD, 256, cycles all stages stay asserted after sw_rst_req, 1..2^CNT_W-1

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous assertion, active-low
ext_rst_n  in  1  external reset, already synchronised to clk, active-low
pll_locked  in  NUM_PLLS  lock flags, already synchronised to clk
sw_rst_req  in  1  single-cycle software reset request pulse
stage_rst_n  out  NUM_STAGES  per-stage reset, active-low, registered
seq_done  out  1  high while all stages are released
seq_state  out  2  FSM state: 0 HOLD, 1 RELEASE, 2 RUN, 3 SW_HOLD
lock_loss_cnt  out  8  saturating count of PLL lock-loss events

Behaviour:
- Asynchronous reset (rst_n low):
  - stage_rst_n = 0, seq_done = 0, seq_state = HOLD, lock_loss_cnt = 0.
  - Filter counter, timer and stage index are cleared.
- Define all_ok = &pll_locked && ext_rst_n.
- Lock filter counter, width clog2(LOCK_FILTER+1):
  - Cleared in any cycle where all_ok = 0.
  - Otherwise increments, saturating at LOCK_FILTER.
  - lock_ok = (filter counter == LOCK_FILTER), combinational from the counter.
- HOLD:
  - stage_rst_n = 0, timer = 0, index = 0.
  - When lock_ok, go to RELEASE on the next edge.
- RELEASE:
  - The timer counts up each cycle.
  - When timer == STAGE_DELAY-1: set stage_rst_n[index] = 1, increment index, clear timer.
  - On the release of stage NUM_STAGES-1, go to RUN and set seq_done = 1 on the same edge.
  - Stages that are already released stay high.
- RUN: all stage_rst_n = 1, seq_done = 1. Stay here until an abort event.
- SW_HOLD:
  - stage_rst_n = 0, seq_done = 0, timer counts.
  - When timer == SW_RST_HOLD-1, go to HOLD.
  - If lock_ok still holds, HOLD exits to RELEASE on the following edge.
- Abort priority, checked each cycle, highest first:
  1. all_ok = 0 while in RELEASE, RUN or SW_HOLD:
     - Next edge: stage_rst_n = 0, seq_done = 0, go to HOLD, clear timer and index.
     - lock_loss_cnt += 1, saturating at 255, only if &pll_locked = 0 (an ext_rst_n-only drop is not counted).
     - One count per entry into HOLD, not per cycle.
  2. sw_rst_req while in RELEASE or RUN:
     - Next edge: stage_rst_n = 0, seq_done = 0, go to SW_HOLD, clear timer and index.
     - The filter counter is not cleared.
  3. Normal timer progression.
- sw_rst_req is ignored in HOLD and SW_HOLD; no extension, no queuing.
- Latency: from the first edge at which lock_ok is seen, stage k releases (k+1)*STAGE_DELAY+1 edges later.
- STAGE_DELAY = 1 releases one stage per cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset mid-sequence: rst_n low forces the reset values immediately, whatever the FSM state.

Test Plan:
Bench parameters for all scenarios: NUM_STAGES=5, NUM_PLLS=2, STAGE_DELAY=4, LOCK_FILTER=8, SW_RST_HOLD=16.
- Power-up: rst_n released, then pll_locked=2'b11 and ext_rst_n=1 at edge 0 -> lock_ok after edge 8, RELEASE at edge 9, stage_rst_n bit0 high at edge 13, bits 1..4 at edges 17/21/25/29, seq_done=1 at edge 29, seq_state=2, lock_loss_cnt=0.
- Lock glitch in filter: pll_locked[1] low for 1 cycle at edge 5 -> filter restarts, stage0 releases 8+1+4 edges after lock returns, lock_loss_cnt stays 0 (FSM still in HOLD).
- Lock loss in RUN: pll_locked=2'b01 for 3 cycles -> next edge stage_rst_n=5'b00000, seq_done=0, seq_state=0, lock_loss_cnt=1; full re-sequence after relock (stage0 at relock+13).
- Software reset in RELEASE after stage1 released: sw_rst_req pulse -> next edge stage_rst_n=0, seq_state=3 for 16 cycles, then HOLD, then RELEASE next edge, stage0 released 4 edges later; lock_loss_cnt unchanged.
- Priority and saturation: sw_rst_req and pll drop in the same cycle -> HOLD, not SW_HOLD, counter increments. Then 300 lock-loss events -> lock_loss_cnt=255. sw_rst_req in HOLD -> no state change.
- Async reset mid-RELEASE (after stage2 released): rst_n low -> stage_rst_n=0, seq_done=0, seq_state=0, lock_loss_cnt=0 without a clock edge.
